// File: rtl/rsa_modexp_param_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine:
// register-select encodings, exponent FSM states and the byte-count helper.
package rsa_pkg;

  localparam logic [1:0] SEL_S = 2'd0;
  localparam logic [1:0] SEL_M = 2'd1;
  localparam logic [1:0] SEL_E = 2'd2;
  localparam logic [1:0] SEL_N = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_UPD  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // Number of host-addressable bytes in one operand.
  function automatic int unsigned key_bytes(input int unsigned key_w);
    return key_w / 8;
  endfunction

endpackage

// File: rtl/rsa_modexp_param_if.sv
// Host register bus for rsa_modexp_param.
//   master: host side (drives strobes, select, address, write data)
//   slave : engine side (drives read data, busy, done, err)
interface rsa_modexp_param_if #(
  parameter int unsigned KEY_W = 256
);
  import rsa_pkg::*;

  localparam int unsigned ADDR_W = $clog2(key_bytes(KEY_W));

  logic              we;
  logic              oe;
  logic              start;
  logic [1:0]        reg_sel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_i;
  logic [7:0]        data_o;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output we, oe, start, reg_sel, addr, data_i,
    input  data_o, busy, done, err
  );

  modport slave (
    input  we, oe, start, reg_sel, addr, data_i,
    output data_o, busy, done, err
  );

endinterface

// File: rtl/rsa_modexp_param_mod_mul_il.sv
// Interleaved MSB-first modular multiplier: p = a*b mod n.
// Ports: clk, reset (async, active-high), start (latches a/b/n),
//        a, b, n operands, p result, done (high during the last iteration
//        cycle, so p is final on the following cycle).
// One launch cycle plus KEY_W iteration cycles per product.
module mod_mul_il #(
  parameter int unsigned KEY_W = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  input  logic [KEY_W-1:0] n,
  output logic [KEY_W-1:0] p,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(KEY_W);
  localparam int unsigned EXT_W = KEY_W + 2;

  logic [KEY_W-1:0] a_q, b_q, n_q, p_q, p_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [EXT_W-1:0] n_ext_c, dbl_c, dbl_red_c, add_c, add_red_c;

  // One iteration: P <- 2P mod N, then P <- P + b mod N when the a bit is set.
  always_comb begin
    n_ext_c   = {2'b00, n_q};
    dbl_c     = {1'b0, p_q, 1'b0};
    dbl_red_c = (dbl_c >= n_ext_c) ? (dbl_c - n_ext_c) : dbl_c;
    add_c     = dbl_red_c;
    if (a_q[KEY_W-1]) add_c = dbl_red_c + {2'b00, b_q};
    add_red_c = (add_c >= n_ext_c) ? (add_c - n_ext_c) : add_c;
    p_d       = KEY_W'(add_red_c);
  end

  // Operand latch and iteration counter; a is shifted so its MSB is the current bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      n_q   <= n;
      p_q   <= '0;
      cnt_q <= CNT_W'(KEY_W - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      p_q   <= p_d;
      a_q   <= a_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign p    = p_q;
  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/rsa_modexp_param.sv
// RSA modular-exponentiation engine, S = M^E mod N, right-to-left binary.
// Ports: clk, reset (async, active-high), bus (slave modport of
//        rsa_modexp_param_if: byte-wide host register access, start,
//        busy/done handshake, sticky err).
// Both products are computed for every exponent bit so run time does not
// depend on E; R is only committed when the exponent bit is set.
module rsa_modexp_param #(
  parameter int unsigned KEY_W = 256
) (
  input  logic                clk,
  input  logic                reset,
  rsa_modexp_param_if.slave   bus
);
  import rsa_pkg::*;

  localparam int unsigned NBYTES = key_bytes(KEY_W);
  localparam int unsigned IDX_W  = $clog2(KEY_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_W - 1);

  state_e state_q, state_d;

  logic [KEY_W-1:0] m_q, e_q, n_q, s_q, r_q, b_q;
  logic [IDX_W-1:0] i_q;
  logic [7:0]       data_o_q, data_o_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mul_go_q, mul_go_d;

  logic [KEY_W-1:0] p_rb_c, p_bb_c, sel_reg_c;
  logic             rb_done_c, bb_done_c;
  logic             addr_ok_c, wr_en_c, wr_err_c, start_acc_c, n_zero_c;
  logic [7:0]       rd_byte_c;

  // Host decode.
  assign addr_ok_c   = (32'(bus.addr) < NBYTES);
  assign wr_en_c     = bus.we && !busy_q && (bus.reg_sel != SEL_S) && addr_ok_c;
  assign wr_err_c    = bus.we && (busy_q || (bus.reg_sel == SEL_S));
  assign start_acc_c = bus.start && !busy_q;
  assign n_zero_c    = (n_q == '0);

  // Read-byte mux; out-of-range addresses read as zero.
  always_comb begin
    sel_reg_c = s_q;
    case (bus.reg_sel)
      SEL_M:   sel_reg_c = m_q;
      SEL_E:   sel_reg_c = e_q;
      SEL_N:   sel_reg_c = n_q;
      default: sel_reg_c = s_q;
    endcase
    rd_byte_c = addr_ok_c ? sel_reg_c[{bus.addr, 3'b000} +: 8] : 8'h00;
  end

  // Operand register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      e_q <= '0;
      n_q <= '0;
    end else if (wr_en_c) begin
      case (bus.reg_sel)
        SEL_M:   m_q[{bus.addr, 3'b000} +: 8] <= bus.data_i;
        SEL_E:   e_q[{bus.addr, 3'b000} +: 8] <= bus.data_i;
        SEL_N:   n_q[{bus.addr, 3'b000} +: 8] <= bus.data_i;
        default: ;
      endcase
    end
  end

  // Sticky error: a start clears it, but an error raised in the same cycle wins.
  always_comb begin
    err_d = err_q;
    if (start_acc_c) err_d = 1'b0;
    if (wr_err_c) err_d = 1'b1;
    if ((state_q == ST_LOAD) && n_zero_c) err_d = 1'b1;
    data_o_d = bus.oe ? rd_byte_c : data_o_q;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_acc_c) state_d = ST_LOAD;
      ST_LOAD: state_d = n_zero_c ? ST_IDLE : ST_MUL;
      ST_MUL:  if (rb_done_c && bb_done_c) state_d = ST_UPD;
      ST_UPD:  state_d = (i_q == LAST_IDX) ? ST_FIN : ST_MUL;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, registered; multipliers launch in the first MUL cycle.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = 1'b0;
    mul_go_d = (state_d == ST_MUL) && (state_q != ST_MUL);
    if (state_q == ST_FIN) done_d = 1'b1;
    if ((state_q == ST_LOAD) && n_zero_c) done_d = 1'b1;
  end

  // Output and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mul_go_q <= 1'b0;
    end else begin
      data_o_q <= data_o_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mul_go_q <= mul_go_d;
    end
  end

  // Exponentiation datapath: R/B accumulators, bit counter, result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      b_q <= '0;
      i_q <= '0;
      s_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          r_q <= KEY_W'(1);
          b_q <= m_q;
          i_q <= '0;
          if (n_zero_c) s_q <= '0;
        end
        ST_UPD: begin
          if (e_q[i_q]) r_q <= p_rb_c;
          b_q <= p_bb_c;
          i_q <= i_q + IDX_W'(1);
        end
        ST_FIN:  s_q <= r_q;
        default: ;
      endcase
    end
  end

  mod_mul_il #(.KEY_W(KEY_W)) u_mul_rb (
    .clk   (clk),
    .reset (reset),
    .start (mul_go_q),
    .a     (r_q),
    .b     (b_q),
    .n     (n_q),
    .p     (p_rb_c),
    .done  (rb_done_c)
  );

  mod_mul_il #(.KEY_W(KEY_W)) u_mul_bb (
    .clk   (clk),
    .reset (reset),
    .start (mul_go_q),
    .a     (b_q),
    .b     (b_q),
    .n     (n_q),
    .p     (p_bb_c),
    .done  (bb_done_c)
  );

  assign bus.data_o = data_o_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_rsa_modexp_param.sv
// Bench for rsa_modexp_param: three instances (KEY_W = 16, 256, 24) behind
// one shared host driver; results compared with a big-integer modexp model.
module tb_rsa_modexp_param;
  import rsa_pkg::*;

  logic       clk;
  logic       rst16, rst256, rst24;
  logic       we, oe, start;
  logic [1:0] reg_sel;
  logic [7:0] addr;
  logic [7:0] din;
  int         dsel;

  logic [7:0] dout;
  logic       busy, done, err;

  int n_chk;
  int n_fail;

  rsa_modexp_param_if #(.KEY_W(16))  b16 ();
  rsa_modexp_param_if #(.KEY_W(256)) b256 ();
  rsa_modexp_param_if #(.KEY_W(24))  b24 ();

  assign b16.we       = we && (dsel == 0);
  assign b16.oe       = oe && (dsel == 0);
  assign b16.start    = start && (dsel == 0);
  assign b16.reg_sel  = reg_sel;
  assign b16.addr     = addr[0:0];
  assign b16.data_i   = din;

  assign b256.we      = we && (dsel == 1);
  assign b256.oe      = oe && (dsel == 1);
  assign b256.start   = start && (dsel == 1);
  assign b256.reg_sel = reg_sel;
  assign b256.addr    = addr[4:0];
  assign b256.data_i  = din;

  assign b24.we       = we && (dsel == 2);
  assign b24.oe       = oe && (dsel == 2);
  assign b24.start    = start && (dsel == 2);
  assign b24.reg_sel  = reg_sel;
  assign b24.addr     = addr[1:0];
  assign b24.data_i   = din;

  rsa_modexp_param #(.KEY_W(16))  dut16  (.clk(clk), .reset(rst16),  .bus(b16));
  rsa_modexp_param #(.KEY_W(256)) dut256 (.clk(clk), .reset(rst256), .bus(b256));
  rsa_modexp_param #(.KEY_W(24))  dut24  (.clk(clk), .reset(rst24),  .bus(b24));

  always_comb begin
    case (dsel)
      0: begin dout = b16.data_o;  busy = b16.busy;  done = b16.done;  err = b16.err;  end
      1: begin dout = b256.data_o; busy = b256.busy; done = b256.done; err = b256.err; end
      default: begin dout = b24.data_o; busy = b24.busy; done = b24.done; err = b24.err; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: square-and-multiply on plain wide integers.
  function automatic logic [255:0] ref_modexp(input logic [255:0] m, input logic [255:0] e,
                                              input logic [255:0] n, input int kw);
    logic [511:0] r, b, nn;
    if (n == '0) return '0;
    nn = {256'd0, n};
    r  = 512'd1;
    b  = {256'd0, m};
    for (int i = 0; i < kw; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] rs, input int a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; reg_sel = rs; addr = 8'(a); din = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] rs, input int a, output logic [7:0] v);
    @(negedge clk);
    oe = 1'b1; reg_sel = rs; addr = 8'(a);
    @(negedge clk);
    oe = 1'b0;
    v = dout;
  endtask

  task automatic load(input logic [1:0] rs, input logic [255:0] val, input int nb);
    for (int i = 0; i < nb; i++) wr(rs, i, val[8*i +: 8]);
  endtask

  task automatic readreg(input logic [1:0] rs, input int nb, output logic [255:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < nb; i++) begin
      rd(rs, i, b);
      v[8*i +: 8] = b;
    end
  endtask

  // Pulse start for one cycle, optionally with a write in the same cycle.
  task automatic kick(input bit with_wr, input logic [1:0] ws, input int wa, input logic [7:0] wd);
    @(negedge clk);
    start = 1'b1;
    if (with_wr) begin we = 1'b1; reg_sel = ws; addr = 8'(wa); din = wd; end
    @(negedge clk);
    start = 1'b0; we = 1'b0;
  endtask

  // Count edges until done; cyc = edges after the start-accepting edge.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    @(negedge clk);
    chk("done_single_pulse", 256'(done), 256'd0);
    chk("busy_after_done", 256'(busy), 256'd0);
  endtask

  task automatic run(input int limit, output int cyc);
    kick(1'b0, SEL_M, 0, 8'h00);
    chk("busy_after_start", 256'(busy), 256'd1);
    wait_done(limit, cyc);
  endtask

  initial begin
    logic [255:0] m, e, n, s, v;
    logic [7:0]   b;
    int           cyc;
    n_chk = 0; n_fail = 0;
    we = 0; oe = 0; start = 0; reg_sel = 0; addr = 0; din = 0; dsel = 0;
    rst16 = 1; rst256 = 1; rst24 = 1;
    repeat (3) @(negedge clk);
    rst16 = 0; rst256 = 0; rst24 = 0;

    // Reset state on every instance.
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      #1;
      chk("rst_data_o", 256'(dout), 256'd0);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_done", 256'(done), 256'd0);
      chk("rst_err", 256'(err), 256'd0);
    end

    // ---- KEY_W = 16 ----
    dsel = 0;
    load(SEL_M, 256'd5, 2); load(SEL_E, 256'd3, 2); load(SEL_N, 256'd13, 2);
    run(1000, cyc);
    chk("lat16_a", 256'(cyc), 256'd290);
    rd(SEL_S, 0, b); chk("s16_a_b0", 256'(b), 256'h08);
    rd(SEL_S, 1, b); chk("s16_a_b1", 256'(b), 256'h00);
    chk("s16_a_model", 256'd8, ref_modexp(256'd5, 256'd3, 256'd13, 16));

    load(SEL_M, 256'd2, 2); load(SEL_E, 256'd10, 2); load(SEL_N, 256'd1000, 2);
    run(1000, cyc);
    chk("lat16_b", 256'(cyc), 256'd290);
    readreg(SEL_S, 2, v); chk("s16_b", v, ref_modexp(256'd2, 256'd10, 256'd1000, 16));

    load(SEL_E, 256'd0, 2);
    run(1000, cyc);
    chk("lat16_e0", 256'(cyc), 256'd290);
    readreg(SEL_S, 2, v); chk("s16_e0", v, 256'd1);

    // Activity while busy.
    load(SEL_E, 256'd10, 2);
    kick(1'b0, SEL_M, 0, 8'h00);
    wr(SEL_M, 0, 8'h77);
    chk("err_wr_busy", 256'(err), 256'd1);
    rd(SEL_M, 0, b); chk("m_stable_busy", 256'(b), 256'h02);
    rd(SEL_S, 0, b); chk("s_old_busy", 256'(b), 256'h01);
    kick(1'b0, SEL_M, 0, 8'h00);
    chk("err_start_busy", 256'(err), 256'd1);
    wait_done(1000, cyc);
    readreg(SEL_S, 2, v); chk("s16_busy_run", v, 256'd24);
    chk("err_sticky", 256'(err), 256'd1);
    run(1000, cyc);
    chk("err_cleared", 256'(err), 256'd0);
    chk("lat16_c", 256'(cyc), 256'd290);

    // Random operands with M < N.
    for (int k = 0; k < 3; k++) begin
      n = 256'($urandom_range(65535, 2));
      m = 256'($urandom) % n;
      e = 256'($urandom_range(65535, 0));
      load(SEL_M, m, 2); load(SEL_E, e, 2); load(SEL_N, n, 2);
      run(1000, cyc);
      chk("lat16_rnd", 256'(cyc), 256'd290);
      readreg(SEL_S, 2, v); chk("s16_rnd", v, ref_modexp(m, e, n, 16));
    end

    // N = 0.
    load(SEL_N, 256'd0, 2);
    run(1000, cyc);
    chk("lat16_n0", 256'(cyc), 256'd1);
    readreg(SEL_S, 2, v); chk("s16_n0", v, 256'd0);
    chk("err_n0", 256'(err), 256'd1);
    load(SEL_M, 256'd5, 2); load(SEL_E, 256'd3, 2); load(SEL_N, 256'd13, 2);
    run(1000, cyc);
    chk("err_after_good", 256'(err), 256'd0);
    wr(SEL_S, 0, 8'hAA);
    chk("err_wr_sel0", 256'(err), 256'd1);
    rd(SEL_S, 0, b); chk("s_unchanged_sel0", 256'(b), 256'h08);

    // ---- KEY_W = 256 ----
    dsel = 1;
    n = rnd256(); n[255] = 1'b1; n[0] = 1'b1;
    m = rnd256() % n;
    e = rnd256();
    load(SEL_M, m, 32); load(SEL_E, e, 32); load(SEL_N, n, 32);
    run(67000, cyc);
    chk("lat256", 256'(cyc), 256'd66050);
    s = ref_modexp(m, e, n, 256);
    readreg(SEL_S, 32, v); chk("s256", v, s);

    kick(1'b0, SEL_M, 0, 8'h00);
    repeat (300) @(negedge clk);
    chk("busy256_mid", 256'(busy), 256'd1);
    wr(SEL_E, 0, 8'h11);
    chk("err256_mid", 256'(err), 256'd1);
    rd(SEL_S, 0, b); chk("s256_read_busy", 256'(b), 256'(s[7:0]));
    rst256 = 1'b1;
    #2;
    chk("rst256_busy", 256'(busy), 256'd0);
    chk("rst256_data_o", 256'(dout), 256'd0);
    chk("rst256_err", 256'(err), 256'd0);
    @(negedge clk);
    rst256 = 1'b0;
    readreg(SEL_S, 32, v); chk("rst256_s", v, 256'd0);
    readreg(SEL_M, 32, v); chk("rst256_m", v, 256'd0);
    readreg(SEL_E, 32, v); chk("rst256_e", v, 256'd0);
    readreg(SEL_N, 32, v); chk("rst256_n", v, 256'd0);

    // ---- KEY_W = 24 ----
    dsel = 2;
    wr(SEL_M, 0, 8'h5A);
    rd(SEL_M, 0, b); chk("m24_b0", 256'(b), 256'h5A);
    wr(SEL_M, 3, 8'hFF);
    chk("err24_oob", 256'(err), 256'd0);
    rd(SEL_M, 3, b); chk("rd24_oob", 256'(b), 256'h00);
    readreg(SEL_M, 3, v); chk("m24_after_oob", v, 256'h00005A);

    load(SEL_M, 256'd3, 3); load(SEL_E, 256'd5, 3); load(SEL_N, 256'd1000, 3);
    kick(1'b1, SEL_M, 0, 8'h07);
    wait_done(2000, cyc);
    chk("lat24", 256'(cyc), 256'd626);
    readreg(SEL_S, 3, v); chk("s24_start_wr", v, ref_modexp(256'd7, 256'd5, 256'd1000, 24));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
